// File: rtl/neuron_acc_seq.sv
// neuron_acc_seq: sequences one shared PROD_W+ACC_W adder to compute a neuron
// pre-activation, bias + sum of N_INPUTS streamed products, saturating after every add.
module neuron_acc_seq #(
    parameter int unsigned N_INPUTS = 16,
    parameter int unsigned PROD_W   = 20,
    parameter int unsigned ACC_W    = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ACC_W-1:0]  bias,
    output logic              busy,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              sat_flag
);

    localparam int unsigned CNT_W = $clog2(N_INPUTS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sat_q, sat_d;

    logic [ACC_W:0]     raw;
    logic [ACC_W-1:0]   add_sat;
    logic               add_clamped;
    logic               xfer;

    // Shared adder: full-precision sum of sign-extended operands, then clamp to ACC_W bits
    always_comb begin
        raw = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod} + {acc_q[ACC_W-1], acc_q};
        add_clamped = (raw[ACC_W] != raw[ACC_W-1]);
        if (add_clamped) begin
            add_sat = raw[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            add_sat = raw[ACC_W-1:0];
        end
    end

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequence
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        xfer    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                xfer = prod_valid;
                if (xfer) begin
                    acc_d = add_sat;
                    cnt_d = cnt_q + 1'b1;
                    if (add_clamped) begin
                        sat_d = 1'b1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        sum_d   = add_sat;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
        end
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        busy       = (state_q != IDLE);
        prod_ready = (state_q == ACCUM);
        out_valid  = (state_q == DONE);
        sum        = sum_q;
        sat_flag   = sat_q;
    end

endmodule

// File: tb/tb_neuron_acc_seq.sv
// Directed bench for neuron_acc_seq: a 4-input instance and a 1-input instance.
module tb_neuron_acc_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start, prod_valid, out_ready;
    logic [21:0] bias;
    logic [19:0] prod;
    logic        busy, prod_ready, out_valid, sat_flag;
    logic [21:0] sum;

    logic        start1, prod_valid1, out_ready1;
    logic [21:0] bias1;
    logic [19:0] prod1;
    logic        busy1, prod_ready1, out_valid1, sat_flag1;
    logic [21:0] sum1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_acc_seq #(.N_INPUTS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod(prod),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .sat_flag(sat_flag)
    );

    neuron_acc_seq #(.N_INPUTS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bias(bias1), .busy(busy1),
        .prod_valid(prod_valid1), .prod_ready(prod_ready1), .prod(prod1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .sat_flag(sat_flag1)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b);
        start = 1'b1;
        bias  = b[21:0];
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_prod_ready", prod_ready, 1);
    endtask

    // Back-to-back job on the 4-input instance, checks result timing and value
    task automatic job4(input string tag, input int b, input int p0, input int p1,
                        input int p2, input int p3, input int exp_sum, input int exp_sat);
        int p[4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        do_start(b);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_ov_early"}, out_valid, 0);
            prod_valid = 1'b1;
            prod       = p[i][19:0];
            tick();
        end
        prod_valid = 1'b0;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_sum"}, $signed(sum), exp_sum);
        chk({tag, "_sat"}, sat_flag, exp_sat);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prod_valid = 1'b0; out_ready = 1'b0;
        bias = '0; prod = '0;
        start1 = 1'b0; prod_valid1 = 1'b0; out_ready1 = 1'b0; bias1 = '0; prod1 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_prod_ready", prod_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", $signed(sum), 0);
        chk("rst_sat", sat_flag, 0);

        // prod_valid in IDLE must be ignored
        prod_valid = 1'b1; prod = 20'd777;
        tick(); tick();
        prod_valid = 1'b0;
        chk("idle_ignore_busy", busy, 0);

        job4("basic", 100, 10, -20, 30, 40, 160, 0);
        job4("possat", 2097000, 100, 100, -50, 0, 2097101, 1);
        job4("negsat", -2097152, -524288, -524288, -524288, -524288, -2097152, 1);
        job4("clear", 0, 1, 1, 1, 1, 4, 0);

        // Bubbles: valid pattern 1,0,0,1,1,0,1 with products 5,6,7,8
        begin
            logic [6:0] vpat;
            int vals[4];
            int k;
            vpat = 7'b1011001;
            vals[0] = 5; vals[1] = 6; vals[2] = 7; vals[3] = 8;
            k = 0;
            do_start(0);
            for (int i = 0; i < 7; i++) begin
                chk("bub_ov_early", out_valid, 0);
                prod_valid = vpat[i];
                prod       = vpat[i] ? vals[k][19:0] : 20'd999;
                if (vpat[i]) k++;
                tick();
            end
            prod_valid = 1'b0;
            chk("bub_out_valid", out_valid, 1);
            chk("bub_sum", $signed(sum), 26);
        end

        // Backpressure: hold result, ignore start and products
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; bias = 22'(i * 11);
            prod_valid = 1'b1; prod = 20'd1000;
            tick();
            chk("bp_sum", $signed(sum), 26);
            chk("bp_prod_ready", prod_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        prod_valid = 1'b0;
        out_ready = 1'b1; start = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("bp_release_busy", busy, 0);
        chk("bp_release_ov", out_valid, 0);
        tick();
        chk("bp_start_ignored", busy, 0);

        // Reset in the middle of accumulation
        do_start(50);
        prod_valid = 1'b1; prod = 20'd3;
        tick(); tick();
        prod_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_sum", $signed(sum), 0);
        chk("mid_rst_prod_ready", prod_ready, 0);
        job4("post_rst", 5, 1, 2, 3, 4, 15, 0);

        // Single-input instance, with products offered while idle
        prod_valid1 = 1'b1; prod1 = 20'd500;
        tick(); tick();
        start1 = 1'b1; bias1 = 22'h3FFFFD;
        tick();
        start1 = 1'b0;
        chk("n1_ov_early", out_valid1, 0);
        chk("n1_prod_ready", prod_ready1, 1);
        prod1 = 20'd7;
        tick();
        prod_valid1 = 1'b0;
        chk("n1_out_valid", out_valid1, 1);
        chk("n1_sum", $signed(sum1), 4);
        chk("n1_sat", sat_flag1, 0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("n1_idle", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_acc_seq.md
Name: neuron_acc_seq

Overview:
Sequencer for the neuron accumulation datapath. Owns one signed 20-bit + 22-bit adder with a 23-bit result and reuses it every cycle. It computes one neuron pre-activation: bias plus N_INPUTS streamed signed products. The output is saturated to 22 bits and sits between the multiplier array and the activation stage.

Parameters:
N_INPUTS, 16, number of products accumulated per job (legal range 1..1023)
PROD_W, 20, signed product width (fixed; the adder's a-operand)
ACC_W, 22, signed accumulator/bias/result width (fixed; the adder's b-operand)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle job request; sampled only in IDLE
bias  in  22  signed bias; latched on accepted start
busy  out  1  high in ACCUM and DONE
prod_valid  in  1  product stream valid
prod_ready  out  1  product stream ready
prod  in  20  signed product
out_valid  out  1  result valid
out_ready  in  1  downstream ready
sum  out  22  signed saturated result
sat_flag  out  1  sticky: at least one add in this job saturated

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state:
  - FSM goes to IDLE.
  - acc=0, cnt=0, sum=0, sat_flag=0.
  - busy=0, prod_ready=0, out_valid=0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-job discards the partial sum; no output is produced.
- Output timing:
  - busy, prod_ready and out_valid are decoded from the registered state.
  - sum and sat_flag are registers.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: busy=0, prod_ready=0, out_valid=0. When start=1: acc<=bias, cnt<=0, sat_flag<=0, go to ACCUM. start is ignored in ACCUM and DONE.
  - ACCUM: prod_ready=1, busy=1. A transfer occurs when prod_valid&&prod_ready. On each transfer: acc<=sat22(sext23(prod)+sext23(acc)) and cnt<=cnt+1. On the transfer with cnt==N_INPUTS-1: sum<=the saturated value and go to DONE. No transfer means acc, cnt and state hold; bubbles are allowed.
  - DONE: out_valid=1, busy=1, prod_ready=0. sum holds stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE. A start in that same cycle is ignored; the next job needs start in IDLE.
- Arithmetic:
  - The 23-bit raw sum is full precision; there is no overflow at the adder.
  - sat22: raw > 2097151 gives 2097151; raw < -2097152 gives -2097152; otherwise raw[21:0].
  - Saturation is applied after every add, not only at the end.
  - sat_flag<=1 on any clamped add; it stays set until the next accepted start.
- Latency and throughput:
  - With start in cycle t and prod_valid held high, products transfer in cycles t+1..t+N_INPUTS.
  - out_valid rises in cycle t+N_INPUTS+1.
  - Minimum job period is N_INPUTS+2 cycles with out_ready=1.
- Boundary conditions:
  - N_INPUTS=1: a single transfer goes straight to DONE.
  - prod_valid outside ACCUM is ignored and does not change acc.
  - cnt width is clog2(N_INPUTS)+1; cnt never wraps within a job.
  - Once saturated, acc can move back into range on later adds; there is no latching at the rail.

Test Plan:
- N_INPUTS=4, bias=100, prods 10,-20,30,40 back-to-back -> out_valid at start+5, sum=160, sat_flag=0.
- Positive saturation: bias=2097000, prods 100,100,-50,0 -> sum=2097101 (clamps at 2097151 on add 2, then 2097151-50), sat_flag=1.
- Negative extremes: bias=-2097152, prods -524288 x4 -> sum=-2097152, sat_flag=1. Then a new job with bias=0, prods 1,1,1,1 -> sum=4, sat_flag=0 (flag cleared by start).
- Bubbles and backpressure:
  - prod_valid toggles 1,0,0,1,1,0,1 -> exactly 4 transfers; out_valid after the 4th.
  - Hold out_ready=0 for 5 cycles -> sum stable, prod_ready=0, start pulses ignored.
  - out_ready=1 -> IDLE next cycle.
- Reset mid-ACCUM after 2 transfers -> next cycle: busy=0, out_valid=0, sum=0. A following clean job with bias=5, prods 1,2,3,4 -> sum=15.
- N_INPUTS=1: bias=-3, prod=7 -> out_valid at start+2, sum=4. prod_valid asserted in IDLE beforehand leaves the result unaffected.
